hazard_md_ctrl: RTL and testbench

- Stall/flush controller for the ID/EX boundary of the 5-stage MIPS pipeline.
- Detects register RAW hazards from Tuse/Tnew, and sequences the multiply/divide unit's busy window.
- Drives the freeze of PC and the D register, and the bubble-insert clear of the E register.
- Also keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_md_ctrl_pkg.sv | 25 ++
 rtl/hazard_md_ctrl_md_busy_seq.sv | 65 ++++++
 rtl/hazard_md_ctrl.sv | 86 ++++++++
 tb/tb_hazard_md_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hazard_md_ctrl_pkg.sv
// Shared pipeline definitions for the ID/EX hazard controller: Tuse/Tnew
// encodings, the $0 register, md unit latency defaults and the sequencer states.
package hazard_md_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A source read in D collides with a later-stage writer whose result is not yet forwardable.
    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_md_ctrl_md_busy_seq.sv
// Multiply/divide busy sequencer: issues the start pulse, counts the busy
// window down and flags starts that arrive while the unit is still computing.
module md_busy_seq
    import hazard_md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic E_md_start_i,
    input  logic E_md_div_i,
    output logic md_start_o,
    output logic md_busy_o,
    output logic md_err_o
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               err_q;
    logic [CNT_W-1:0]   load_d;

    assign md_start_o = !reset && E_md_start_i && !busy_q;
    assign load_d     = E_md_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign md_busy_o  = busy_q;
    assign md_err_o   = err_q;

    // busy_q mirrors (cnt != 0) one-for-one, so a start is only ever accepted from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (E_md_start_i && busy_q) begin
                err_q <= 1'b1;
            end
            case (state_q)
                MD_IDLE: begin
                    if (md_start_o) begin
                        cnt_q   <= load_d;
                        busy_q  <= 1'b1;
                        state_q <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_md_ctrl.sv
// ID/EX stall controller: register RAW detection from Tuse/Tnew, md unit
// interlock, and a saturating stalled-cycle counter.
module hazard_md_ctrl
    import hazard_md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err,
    output logic [31:0] stall_cnt
);

    logic [4:0]  src_reg  [2];
    logic [1:0]  src_tuse [2];
    logic [1:0]  src_haz;
    logic        md_haz;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign src_reg[0]  = D_rs;
    assign src_reg[1]  = D_rt;
    assign src_tuse[0] = D_Tuse_rs;
    assign src_tuse[1] = D_Tuse_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_haz[gi] = (src_reg[gi] != REG_ZERO) && (src_tuse[gi] != TUSE_NONE) &&
                                 (raw_hit(src_reg[gi], src_tuse[gi], E_A3, E_Tnew) ||
                                  raw_hit(src_reg[gi], src_tuse[gi], M_A3, M_Tnew));
        end
    endgenerate

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk          (clk),
        .reset        (reset),
        .E_md_start_i (E_md_start),
        .E_md_div_i   (E_md_div),
        .md_start_o   (md_start),
        .md_busy_o    (md_busy),
        .md_err_o     (md_err)
    );

    // A start sitting in E counts as busy for an md instruction in D.
    assign md_haz = D_is_md && (md_start || md_busy);
    assign stall  = !reset && ((|src_haz) || md_haz);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Scoreboard bench for hazard_md_ctrl: each directed cycle pushes its expected
// outputs; a negedge monitor pops and compares them.
module tb_hazard_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  D_rs = '0, D_rt = '0, E_A3 = '0, M_A3 = '0;
    logic [1:0]  D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, E_Tnew = '0, M_Tnew = '0;
    logic        D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic        stall, md_start, md_busy, md_err;
    logic [31:0] stall_cnt;

    typedef struct {
        int          id;
        logic        stall;
        logic        start;
        logic        busy;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          txn_id   = 0;
    logic [31:0] model_cnt = '0;

    hazard_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_A3       (E_A3),
        .E_Tnew     (E_Tnew),
        .M_A3       (M_A3),
        .M_Tnew     (M_Tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .md_err     (md_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL txn %0d %s: got %0d expected %0d", id, name, act, exp);
    endtask

    // One cycle of inputs; arst raises reset mid-cycle, between clock edges.
    task automatic step(
        input logic rst_v, input logic arst,
        input logic [4:0] rs, input logic [1:0] tur,
        input logic [4:0] rt, input logic [1:0] tut,
        input logic md,
        input logic [4:0] ea3, input logic [1:0] etn,
        input logic [4:0] ma3, input logic [1:0] mtn,
        input logic es, input logic ed,
        input logic xs, input logic xst, input logic xb, input logic xe
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; D_rs = rs; D_Tuse_rs = tur; D_rt = rt; D_Tuse_rt = tut;
        D_is_md = md; E_A3 = ea3; E_Tnew = etn; M_A3 = ma3; M_Tnew = mtn;
        E_md_start = es; E_md_div = ed;
        if (arst) begin
            #2;
            reset = 1'b1;
        end
        if (rst_v || arst) model_cnt = '0;
        e.id = txn_id; e.stall = xs; e.start = xst; e.busy = xb; e.err = xe; e.cnt = model_cnt;
        sb_q.push_back(e);
        txn_id++;
        if (!(rst_v || arst) && xs) model_cnt = model_cnt + 32'd1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn %0d: stall=%0b start=%0b busy=%0b err=%0b cnt=%0d",
                         e.id, stall, md_start, md_busy, md_err, stall_cnt);
                chk("stall",     e.id, 32'(stall),    32'(e.stall));
                chk("md_start",  e.id, 32'(md_start), 32'(e.start));
                chk("md_busy",   e.id, 32'(md_busy),  32'(e.busy));
                chk("md_err",    e.id, 32'(md_err),   32'(e.err));
                chk("stall_cnt", e.id, stall_cnt,     e.cnt);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // reset held: hazard and start inputs must be gated
        step(1,0, 1,1, 0,3, 1, 1,2, 0,0, 1,0,  0,0,0,0);
        // lw $1 in E, add using $1 in D
        step(0,0, 1,1, 0,3, 0, 1,2, 0,0, 0,0,  1,0,0,0);
        // lw now in M with Tnew 1
        step(0,0, 1,1, 0,3, 0, 0,0, 1,1, 0,0,  0,0,0,0);
        // $0 exemption
        step(0,0, 0,1, 0,3, 0, 0,2, 0,0, 0,0,  0,0,0,0);
        // rt hazard against M, then Tuse == Tnew boundary (no stall)
        step(0,0, 0,3, 5,0, 0, 0,0, 5,1, 0,0,  1,0,0,0);
        step(0,0, 0,3, 5,1, 0, 0,0, 5,1, 0,0,  0,0,0,0);
        // mult in E with mflo in D: start cycle + 5 busy cycles stalled
        step(0,0, 0,3, 0,3, 1, 0,0, 0,0, 1,0,  1,1,0,0);
        for (int i = 0; i < 5; i++) step(0,0, 0,3, 0,3, 1, 0,0, 0,0, 0,0,  1,0,1,0);
        step(0,0, 0,3, 0,3, 1, 0,0, 0,0, 0,0,  0,0,0,0);
        // div start, non-md add in D during the 10 busy cycles
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 1,1,  0,1,0,0);
        for (int i = 0; i < 10; i++) step(0,0, 2,1, 0,3, 0, 3,1, 0,0, 0,0,  0,0,1,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,0,0);
        // mult, then a start while busy at cnt=3: error, no reload
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 1,0,  0,1,0,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,1,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,1,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 1,0,  0,0,1,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,1,1);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,1,1);
        // busy has ended: a div start is accepted immediately
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 1,1,  0,1,0,1);
        for (int i = 0; i < 3; i++) step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,1,1);
        // cnt = 7: async reset mid-cycle clears everything before the next edge
        step(0,1, 0,3, 0,3, 1, 0,0, 0,0, 1,0,  0,0,0,0);
        step(0,0, 0,3, 0,3, 0, 0,0, 0,0, 0,0,  0,0,0,0);
        // operation resumes after reset
        step(0,0, 0,3, 0,3, 1, 0,0, 0,0, 1,0,  1,1,0,0);
        step(0,0, 0,3, 0,3, 1, 0,0, 0,0, 0,0,  1,0,1,0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", txn_id, 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
